// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Contents: FSM state enum, R/W bit encoding, frame-length helper.
package spi_regfile_pkg;

    // Frame-tracking states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } spi_state_t;

    // Value of the first frame bit
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Total SPI clocks in a well-formed frame: R/W + address + data
    function automatic int unsigned frame_len(input int unsigned addr_w,
                                              input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with registered
// rise/fall pulse outputs. Pin-to-pulse latency is SYNC_STAGES+1 clk.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   i_d        : asynchronous input
//   o_level    : synchronised level
//   o_rise     : one-clk pulse on a synchronised 0->1 transition
//   o_fall     : one-clk pulse on a synchronised 1->0 transition
// RST_VAL sets the idle level the chain resets to, so no false edge
// is seen when reset releases with the pin at its idle level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    // Synchroniser chain plus registered edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral with a NUM_REGS x DATA_W register bank.
// Frame (MSB first): R/W bit (1 = write), ADDR_W address bits, DATA_W data bits.
// Writes commit when ncs rises after an exactly full-length frame to an
// in-range address. Read-back is built only when SPI_REGFILE_RDBACK_EN is
// defined; otherwise cipo and cipo_oe are tied low.
// Ports:
//   clk, rst_n     : system clock, async active-low reset
//   i_ncs          : chip select, active-low, asynchronous
//   i_sclk         : SPI clock, idle low, asynchronous
//   i_copi         : controller-out data, asynchronous
//   o_cipo         : peripheral-out data (0 whenever o_cipo_oe is 0)
//   o_cipo_oe      : cipo output enable, high in the data phase of a read
//   o_regs         : flattened register bank, reg k at [k*DATA_W +: DATA_W]
//   o_wr_strobe    : one-clk pulse when a write commits
//   o_wr_addr      : address of the last committed write
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_ncs,
    input  logic                         i_sclk,
    input  logic                         i_copi,
    output logic                         o_cipo,
    output logic                         o_cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs,
    output logic                         o_wr_strobe,
    output logic [ADDR_W-1:0]            o_wr_addr
);

    localparam int unsigned CMD_W     = 1 + ADDR_W;
    localparam int unsigned FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_copi,       w_copi_rise, w_copi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (i_ncs),
        .o_level (w_ncs_level),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (i_sclk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (i_copi),
        .o_level (w_copi),
        .o_rise  (w_copi_rise),
        .o_fall  (w_copi_fall)
    );

    spi_state_t                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [CMD_W-1:0]           r_cmd;
    logic [DATA_W-1:0]          r_data;
    logic [NUM_REGS*DATA_W-1:0] r_regs;
    logic                       r_wr_strobe;
    logic [ADDR_W-1:0]          r_wr_addr;

    logic [CMD_W-1:0]           w_cmd_next;
    logic                       w_cmd_is_read;
    logic                       w_commit;

    // Command word as it will look after shifting in the current copi bit
    assign w_cmd_next    = {r_cmd[CMD_W-2:0], w_copi};
    assign w_cmd_is_read = (w_cmd_next[CMD_W-1] == RW_READ);

    // Commit only a complete, in-range write frame on ncs release
    assign w_commit = w_ncs_rise && (r_state == ST_DONE) &&
                      (r_cmd[CMD_W-1] == RW_WRITE) &&
                      (32'(r_cmd[ADDR_W-1:0]) < NUM_REGS);

    // Frame FSM, shift registers and register bank; ncs events take priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_data      <= '0;
            r_regs      <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_ncs_fall) begin
                // Also covers a glitch mid-frame: restart from a clean count
                r_state <= ST_CMD;
                r_cnt   <= '0;
            end else if (w_ncs_rise) begin
                if (w_commit) begin
                    for (int unsigned k = 0; k < NUM_REGS; k++) begin
                        if (32'(r_cmd[ADDR_W-1:0]) == k) begin
                            r_regs[k*DATA_W +: DATA_W] <= r_data;
                        end
                    end
                    r_wr_strobe <= 1'b1;
                    r_wr_addr   <= r_cmd[ADDR_W-1:0];
                end
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (w_sclk_rise) begin
                case (r_state)
                    ST_CMD: begin
                        r_cmd <= w_cmd_next;
                        if (r_cnt == CNT_W'(CMD_W - 1)) begin
                            r_state <= ST_DATA;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        r_data <= {r_data[DATA_W-2:0], w_copi};
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state <= ST_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_DONE: r_state <= ST_ERR;
                    default: ;
                endcase
            end
        end
    end

    assign o_regs      = r_regs;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;

`ifdef SPI_REGFILE_RDBACK_EN
    logic              r_cipo;
    logic              r_cipo_oe;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_addr_done;
    logic              w_unused;

    assign w_addr_done = w_sclk_rise && !w_ncs_fall && !w_ncs_rise &&
                         (r_state == ST_CMD) && (r_cnt == CNT_W'(CMD_W - 1));

    // Register selected by the address being completed; 0 when out of range
    always_comb begin
        w_rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(w_cmd_next[ADDR_W-1:0]) == k) begin
                w_rd_word = r_regs[k*DATA_W +: DATA_W];
            end
        end
    end

    // Shift-out: MSB presented at address completion. The sclk fall right
    // after that rise precedes the first data sample, so shifting starts only
    // once at least one data bit has been clocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cipo    <= 1'b0;
            r_cipo_oe <= 1'b0;
            r_shift   <= '0;
        end else if (w_ncs_fall || w_ncs_rise ||
                     (w_sclk_rise && (r_state == ST_DONE))) begin
            r_cipo    <= 1'b0;
            r_cipo_oe <= 1'b0;
            r_shift   <= '0;
        end else if (w_addr_done) begin
            if (w_cmd_is_read) begin
                r_cipo_oe <= 1'b1;
                r_cipo    <= w_rd_word[DATA_W-1];
                r_shift   <= {w_rd_word[DATA_W-2:0], 1'b0};
            end
        end else if (w_sclk_fall && r_cipo_oe &&
                     ((r_state == ST_DONE) || (r_cnt != '0))) begin
            r_cipo  <= r_shift[DATA_W-1];
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign o_cipo    = r_cipo;
    assign o_cipo_oe = r_cipo_oe;
    assign w_unused  = ^{w_ncs_level, w_sclk_level, w_copi_rise, w_copi_fall};
`else
    logic w_unused;

    assign o_cipo    = 1'b0;
    assign o_cipo_oe = 1'b0;
    assign w_unused  = ^{w_ncs_level, w_sclk_level, w_copi_rise, w_copi_fall,
                         w_sclk_fall, w_cmd_is_read};
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile: directed frames followed by random
// frames, checked against a behavioural register-bank model. Works with
// SPI_REGFILE_RDBACK_EN either defined or undefined.
module tb_spi_regfile;

    localparam int unsigned NREG = 5;
    localparam int unsigned HALF = 8;     // clk cycles per sclk phase
`ifdef SPI_REGFILE_RDBACK_EN
    localparam bit RDBACK = 1'b1;
`else
    localparam bit RDBACK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_ncs;
    logic              i_sclk;
    logic              i_copi;
    logic              o_cipo;
    logic              o_cipo_oe;
    logic [NREG*8-1:0] o_regs;
    logic              o_wr_strobe;
    logic [6:0]        o_wr_addr;

    spi_regfile #(
        .NUM_REGS    (NREG),
        .ADDR_W      (7),
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ncs       (i_ncs),
        .i_sclk      (i_sclk),
        .i_copi      (i_copi),
        .o_cipo      (o_cipo),
        .o_cipo_oe   (o_cipo_oe),
        .o_regs      (o_regs),
        .o_wr_strobe (o_wr_strobe),
        .o_wr_addr   (o_wr_addr)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int strobe_total = 0;

    logic [7:0] m_regs [NREG];
    logic [6:0] m_wr_addr;

    // Count clk cycles with wr_strobe high (a two-cycle pulse counts twice)
    always @(negedge clk) begin
        if (o_wr_strobe === 1'b1) strobe_total++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < NREG; k++) v[k*8 +: 8] = m_regs[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
        m_wr_addr = 7'd0;
    endtask

    task automatic check_outputs_idle(input string tag);
        check_eq({tag, "_regs"},    64'(o_regs),      model_flat());
        check_eq({tag, "_waddr"},   64'(o_wr_addr),   64'(m_wr_addr));
        check_eq({tag, "_cipo_oe"}, 64'(o_cipo_oe),   64'd0);
        check_eq({tag, "_cipo"},    64'(o_cipo),      64'd0);
    endtask

    // One SPI transaction of nbits clocks. Bits beyond 16 are random filler.
    // When finish is 0 the frame is left open (ncs low, sclk low).
    task automatic spi_frame(input logic rw, input logic [6:0] addr,
                             input logic [7:0] data, input int nbits,
                             input bit finish);
        logic [15:0] fr;
        logic [7:0]  rd_word;
        bit          is_rd;
        bit          commit;
        logic        e_oe;
        logic        e_cipo;
        int          s0;
        fr      = {rw, addr, data};
        rd_word = (int'(addr) < NREG) ? m_regs[int'(addr)] : 8'h00;
        is_rd   = RDBACK && (rw == 1'b0);
        s0      = strobe_total;
        i_ncs   = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            i_copi = (i < 16) ? fr[15-i] : 1'($urandom);
            wait_clk(HALF);
            // Expected pins just before this bit's sampling edge
            e_oe   = 1'b0;
            e_cipo = 1'b0;
            if (is_rd && i >= 8 && i <= 16) begin
                e_oe   = 1'b1;
                e_cipo = (i <= 15) ? rd_word[15-i] : 1'b0;
            end
            check_eq($sformatf("oe_bit%0d", i),   64'(o_cipo_oe), 64'(e_oe));
            check_eq($sformatf("cipo_bit%0d", i), 64'(o_cipo),    64'(e_cipo));
            i_sclk = 1'b1;
            wait_clk(HALF);
            i_sclk = 1'b0;
        end
        if (finish) begin
            wait_clk(HALF);
            i_ncs = 1'b1;
            wait_clk(10);
            commit = (nbits == 16) && (rw == 1'b1) && (int'(addr) < NREG);
            if (commit) begin
                m_regs[int'(addr)] = data;
                m_wr_addr          = addr;
            end
            check_eq("strobes", 64'(strobe_total - s0), commit ? 64'd1 : 64'd0);
            check_outputs_idle("post");
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        i_ncs  = 1'b1;
        i_sclk = 1'b0;
        i_copi = 1'b0;
        model_reset();
        wait_clk(4);
        check_outputs_idle("reset");
        check_eq("reset_strobe", 64'(o_wr_strobe), 64'd0);
        rst_n = 1'b1;
        wait_clk(6);

        // Write reg 2 = 0xA5, then read it back
        spi_frame(1'b1, 7'd2, 8'hA5, 16, 1'b1);
        spi_frame(1'b0, 7'd2, 8'h00, 16, 1'b1);

        // Short and over-length writes to reg 0
        spi_frame(1'b1, 7'd0, 8'h5A, 15, 1'b1);
        spi_frame(1'b1, 7'd0, 8'h5A, 17, 1'b1);

        // Out-of-range write and read
        spi_frame(1'b1, 7'h10, 8'h77, 16, 1'b1);
        spi_frame(1'b0, 7'h10, 8'h00, 16, 1'b1);

        // Reset after 10 bits of a write to reg 1 = 0xFF
        spi_frame(1'b1, 7'd4, 8'hC3, 16, 1'b1);
        spi_frame(1'b1, 7'd1, 8'hFF, 10, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs_idle("midrst");
        check_eq("midrst_strobe", 64'(o_wr_strobe), 64'd0);
        i_ncs  = 1'b1;
        i_sclk = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        spi_frame(1'b1, 7'd1, 8'h3C, 16, 1'b1);
        spi_frame(1'b0, 7'd1, 8'h00, 16, 1'b1);

        // Randomised frames: mixed R/W, lengths and address ranges
        for (int t = 0; t < 40; t++) begin
            logic       rw;
            logic [6:0] addr;
            logic [7:0] data;
            int         len;
            int         sel;
            rw   = 1'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 7'($urandom)
                                               : 7'($urandom_range(0, 6));
            data = 8'($urandom);
            sel  = int'($urandom_range(0, 9));
            len  = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            spi_frame(rw, addr, data, len, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI mode-0 peripheral with an internal register bank of NUM_REGS × DATA_W bits, supporting both write and read-back transactions. Sits between the chip's SPI pins and the downstream output-enable / PWM logic, replacing the fixed five-register write-only peripheral. All SPI inputs are asynchronous to clk and are synchronised and edge-detected inside the block.

## Interface
- NUM_REGS, 5, number of implemented registers (1..2^ADDR_W)
- ADDR_W, 7, address field width in the frame
- DATA_W, 8, register and data field width
- SYNC_STAGES, 2, flip-flops per input synchroniser (≥2)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ncs  in  1  chip select, active-low, async
- sclk  in  1  SPI clock, async, idle low
- copi  in  1  controller-out data, async
- cipo  out  1  peripheral-out data
- cipo_oe  out  1  cipo output enable
- regs  out  NUM_REGS*DATA_W  flattened register bank, reg k at [k*DATA_W +: DATA_W]
- wr_strobe  out  1  one-clk pulse when a write commits
- wr_addr  out  ADDR_W  address of the last committed write

## Operation
- Frame, MSB first: 1 R/W bit (1 = write, 0 = read), ADDR_W address bits, DATA_W data bits; FRAME_LEN = 1+ADDR_W+DATA_W.
- COPI sampled on synchronised SCLK rising edge; CIPO updated on synchronised SCLK falling edge.
- FSM: IDLE → CMD on ncs falling edge; CMD shifts R/W+address; after 1+ADDR_W bits → DATA; after DATA_W more bits → DONE; any further SCLK rising edge in DONE → ERR; ncs rising edge in any state → IDLE.
- Write commit only on ncs rising edge from DONE with R/W=1 and address < NUM_REGS: reg updated, wr_strobe pulses, wr_addr updated.
- Short frames (ncs rises in CMD/DATA), over-length frames (ERR) and out-of-range addresses: no register change, no wr_strobe.
- Read: on the SCLK rising edge completing the address, shift-out register loads reg[addr] (0 if address ≥ NUM_REGS); MSB on cipo immediately, next bits on each subsequent SCLK falling edge. cipo_oe = 1 only in DATA/DONE of a read frame; cipo = 0 when cipo_oe = 0.
- ncs falling edge while not IDLE (glitch) restarts CMD with bit count cleared.

## Timing
- Reset: regs all 0, cipo 0, cipo_oe 0, wr_strobe 0, wr_addr 0, FSM IDLE, synchronisers at idle levels (ncs 1, sclk 0, copi 0).
- Input-to-edge latency: SYNC_STAGES+1 clk.
- Commit latency: regs and wr_strobe change SYNC_STAGES+2 clk after the ncs pin rises.
- Read data: first bit valid SYNC_STAGES+2 clk after the last address SCLK rise; later bits the same latency after each SCLK fall.
- sclk high and low phases each ≥ SYNC_STAGES+3 clk; ncs setup/hold to sclk ≥ SYNC_STAGES+3 clk.
- Reset mid-frame: frame discarded, all outputs to reset values immediately.

## Configuration
- SPI_REGFILE_RDBACK_EN defined: read transactions as above.
- Undefined: read frames are treated as write-length frames and discarded at commit; no shift-out logic; cipo and cipo_oe tied 0.

## Structure
- Package spi_regfile_pkg: FSM state enum (IDLE, CMD, DATA, DONE, ERR), R/W bit encoding constants, FRAME_LEN helper function.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs, parameterised reset level; instantiated for ncs, sclk, copi.

## Test plan
- Write reg 2 = 0xA5 (frame 1_0000010_10100101) → regs[2] = 0xA5, others 0, one wr_strobe pulse, wr_addr = 2.
- Following read of reg 2 (0_0000010 + 8 dummy clocks) → cipo sequence 1,0,1,0,0,1,0,1; cipo_oe high for the data phase only; regs unchanged.
- 15-bit write frame to reg 0 → regs unchanged, no wr_strobe; 17-bit frame → same.
- Write addr 0x10 with NUM_REGS = 5 → no change, no strobe; read addr 0x10 → cipo returns 0x00.
- rst_n asserted after 10 bits of a write to reg 1 = 0xFF → all outputs 0; next valid write to reg 1 = 0x3C commits normally.
- Macro undefined: read frame of reg 2 → cipo and cipo_oe stay 0, regs unchanged.
